// File: rtl/tlul_sram_device.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tlul_pkg
// Minimal TL-UL channel definitions shared by the SRAM device and its users.
// A-channel opcodes, D-channel opcodes and the two packed channel bundles.
// -----------------------------------------------------------------------------
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  localparam logic [7:0] DUserDefault   = 8'h00;

  // Host to device: A channel plus the D-channel ready.
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [7:0]  a_user;
    logic        d_ready;
  } tl_h2d_t;

  // Device to host: D channel plus the A-channel ready.
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// -----------------------------------------------------------------------------
// tlul_sram_device
// TL-UL responder backed by a word-addressed register memory. Accepts a single
// A-channel request, optionally waits RespDelay cycles, then presents a
// registered D-channel response until the host takes it.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (memory contents are kept)
//   tl_i    - A channel and d_ready from the host
//   tl_o    - D channel and a_ready to the host, all fields registered
// -----------------------------------------------------------------------------
module tlul_sram_device
  import tlul_pkg::*;
#(
  parameter int Depth     = 256,
  parameter int RespDelay = 0
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  localparam int AW = $clog2(Depth);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  tl_d2h_t       rsp_q, rsp_d;

  logic [31:0]   mem_q [Depth];

  logic          accept;
  logic          isGet;
  logic          isPut;
  logic          reqErr;
  logic          wrEn;
  logic [AW-1:0] wordIdx;
  logic [31:0]   rdData;
  logic [31:0]   wrMerged;

  // a_ready is taken from the output register, so nothing is accepted on the
  // first edge after reset release while a_ready is still low.
  assign accept  = (state_q == StIdle) && rsp_q.a_ready && tl_i.a_valid;
  assign wordIdx = tl_i.a_address[AW+1:2];
  assign isGet   = (tl_i.a_opcode == Get);
  assign isPut   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign rdData  = mem_q[wordIdx];
  assign wrEn    = accept && isPut && !reqErr;

  // Request legality: any address bit above the memory, an oversize access,
  // misalignment, an unknown opcode, or a full put that is not a full word.
  always_comb begin
    reqErr = 1'b0;
    if ((tl_i.a_address >> (AW + 2)) != 32'd0) reqErr = 1'b1;
    if (tl_i.a_size == 2'd3) reqErr = 1'b1;
    if ((tl_i.a_size == 2'd1) && tl_i.a_address[0]) reqErr = 1'b1;
    if ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00)) reqErr = 1'b1;
    if (!isGet && !isPut) reqErr = 1'b1;
    if ((tl_i.a_opcode == PutFullData) && (tl_i.a_size == 2'd2) && (tl_i.a_mask != 4'hF))
      reqErr = 1'b1;
  end

  // Byte-lane merge of the write data into the currently stored word.
  always_comb begin
    wrMerged = rdData;
    for (int k = 0; k < 4; k++) begin
      if (tl_i.a_mask[k]) wrMerged[8*k +: 8] = tl_i.a_data[8*k +: 8];
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem_q[wordIdx] <= wrMerged;
  end

  // Transaction sequencing and construction of the registered response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    case (state_q)
      StIdle: begin
        rsp_d.a_ready = 1'b1;
        if (accept) begin
          rsp_d.a_ready  = 1'b0;
          rsp_d.d_opcode = isGet ? AccessAckData : AccessAck;
          rsp_d.d_param  = 3'd0;
          rsp_d.d_size   = tl_i.a_size;
          rsp_d.d_source = tl_i.a_source;
          rsp_d.d_sink   = 1'b0;
          rsp_d.d_user   = DUserDefault;
          rsp_d.d_error  = reqErr;
          rsp_d.d_data   = (isGet && !reqErr) ? rdData : 32'd0;
          if (RespDelay == 0) begin
            state_d       = StResp;
            rsp_d.d_valid = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(RespDelay - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d       = StResp;
          rsp_d.d_valid = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (tl_i.d_ready) begin
          state_d       = StIdle;
          rsp_d.d_valid = 1'b0;
          rsp_d.a_ready = 1'b1;
        end
      end
      default: begin
        state_d       = StIdle;
        rsp_d.d_valid = 1'b0;
      end
    endcase
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      cnt_q           <= 4'd0;
      rsp_q           <= '0;
      rsp_q.d_opcode  <= AccessAck;
      rsp_q.d_user    <= DUserDefault;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  assign tl_o = rsp_q;

  logic unused_inputs;
  assign unused_inputs = ^{tl_i.a_param, tl_i.a_user};

endmodule

// File: tb/tb_tlul_sram_device.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tlul_sram_device
// Drives TL-UL requests into tlul_sram_device (RespDelay=3) and compares the
// D channel against a transaction-level model every cycle, plus directed
// literal checks for reset, put/get, partial put, errors, delay, backpressure
// and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_tlul_sram_device;
  import tlul_pkg::*;

  localparam int Depth     = 256;
  localparam int RespDelay = 3;

  logic    clk = 1'b0;
  logic    rstN;
  tl_h2d_t tlI;
  tl_d2h_t tlO;

  int compared   = 0;
  int mismatched = 0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  tlul_sram_device #(
    .Depth    (Depth),
    .RespDelay(RespDelay)
  ) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .tl_i  (tlI),
    .tl_o  (tlO)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: a memory array, whether a transaction is outstanding,
  // and how many edges have passed since it was accepted.
  logic [31:0] modelMem [Depth];
  bit          mOut      = 1'b0;
  bit          expReady  = 1'b0;
  bit          expValid  = 1'b0;
  int          mEdges    = 0;
  logic [2:0]  expOpcode = 3'd0;
  logic        expError  = 1'b0;
  logic [1:0]  expSize   = 2'd0;
  logic [7:0]  expSource = 8'd0;
  logic [31:0] expData   = 32'd0;

  function automatic bit modelError(input logic [2:0] op, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [3:0] mask);
    if (addr >= 32'(Depth * 4)) return 1'b1;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && addr[0]) return 1'b1;
    if (size == 2'd2 && (addr % 32'd4) != 32'd0) return 1'b1;
    if (op != PutFullData && op != PutPartialData && op != Get) return 1'b1;
    if (op == PutFullData && size == 2'd2 && mask != 4'hF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelAccept();
    int   idx;
    bit   e;
    logic [31:0] w;
    idx       = int'((tlI.a_address >> 2) % 32'(Depth));
    e         = modelError(tlI.a_opcode, tlI.a_size, tlI.a_address, tlI.a_mask);
    expOpcode = (tlI.a_opcode == Get) ? AccessAckData : AccessAck;
    expError  = e;
    expSize   = tlI.a_size;
    expSource = tlI.a_source;
    expData   = 32'd0;
    if (!e && tlI.a_opcode == Get) expData = modelMem[idx];
    if (!e && tlI.a_opcode != Get) begin
      w = modelMem[idx];
      for (int k = 0; k < 4; k++)
        if (tlI.a_mask[k]) w[8*k +: 8] = tlI.a_data[8*k +: 8];
      modelMem[idx] = w;
    end
  endtask

  // Model update on each edge and on asynchronous reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rstN);
      if (rstN !== 1'b1) begin
        mOut     = 1'b0;
        expReady = 1'b0;
        expValid = 1'b0;
      end else begin
        if (mOut) begin
          if (expValid && tlI.d_ready) begin
            mOut     = 1'b0;
            expReady = 1'b1;
          end else begin
            mEdges++;
          end
        end else if (expReady && tlI.a_valid) begin
          modelAccept();
          mOut     = 1'b1;
          mEdges   = 1;
          expReady = 1'b0;
        end else begin
          expReady = 1'b1;
        end
        expValid = mOut && (mEdges >= RespDelay + 1);
      end
    end
  end

  // Every-cycle comparison of the DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cyc_a_ready", 32'(tlO.a_ready), 32'(expReady));
      checkOutput("cyc_d_valid", 32'(tlO.d_valid), 32'(expValid));
      if (expValid) begin
        checkOutput("cyc_d_opcode", 32'(tlO.d_opcode), 32'(expOpcode));
        checkOutput("cyc_d_error",  32'(tlO.d_error),  32'(expError));
        checkOutput("cyc_d_size",   32'(tlO.d_size),   32'(expSize));
        checkOutput("cyc_d_source", 32'(tlO.d_source), 32'(expSource));
        checkOutput("cyc_d_param",  32'(tlO.d_param),  32'd0);
        checkOutput("cyc_d_sink",   32'(tlO.d_sink),   32'd0);
        checkOutput("cyc_d_user",   32'(tlO.d_user),   32'(DUserDefault));
        if (!$isunknown(expData)) checkOutput("cyc_d_data", tlO.d_data, expData);
      end
    end
  end

  // One complete transaction: request, wait for accept, optionally keep junk
  // on the A channel while busy, wait for the response, hold off d_ready.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, input logic [7:0] src,
                               input int holdOff, input bit junk,
                               output tl_d2h_t rsp, output int latency);
    bit ok;
    int n;
    rsp     = '0;
    latency = 0;
    @(posedge clk);
    #1;
    tlI.a_valid   = 1'b1;
    tlI.a_opcode  = op;
    tlI.a_param   = 3'd0;
    tlI.a_size    = size;
    tlI.a_source  = src;
    tlI.a_address = addr;
    tlI.a_data    = data;
    tlI.a_mask    = mask;
    tlI.a_user    = 8'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tlO.a_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      tlI.a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (junk) begin
      tlI.a_opcode  = PutFullData;
      tlI.a_size    = 2'd2;
      tlI.a_address = 32'($urandom_range(0, 15)) * 32'd4;
      tlI.a_data    = $urandom;
      tlI.a_mask    = 4'hF;
    end else begin
      tlI.a_valid = 1'b0;
    end
    n  = 1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tlO.d_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    latency = n;
    rsp     = tlO;
    if (!ok) begin
      checkOutput("response_timeout", 32'd0, 32'd1);
      tlI.a_valid = 1'b0;
      return;
    end
    for (int i = 0; i < holdOff; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_d_valid", 32'(tlO.d_valid), 32'd1);
      checkOutput("hold_a_ready", 32'(tlO.a_ready), 32'd0);
    end
    tlI.d_ready = 1'b1;
    @(posedge clk);
    #1;
    tlI.d_ready = 1'b0;
    tlI.a_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tl_d2h_t rsp;
    int      lat;
    int      seen;
    bit      ok;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    int          r;

    tlI  = '0;
    rstN = 1'b0;

    // Reset phase.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_a_ready", 32'(tlO.a_ready), 32'd0);
      checkOutput("rst_d_valid", 32'(tlO.d_valid), 32'd0);
    end
    checkOutput("rst_d_data",   tlO.d_data,           32'd0);
    checkOutput("rst_d_error",  32'(tlO.d_error),     32'd0);
    checkOutput("rst_d_opcode", 32'(tlO.d_opcode),    32'(AccessAck));
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("a_ready_before_edge", 32'(tlO.a_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("a_ready_after_release", 32'(tlO.a_ready), 32'd1);

    // Initialise the working window of 16 words.
    for (int i = 0; i < 16; i++)
      applyStimulus(PutFullData, 2'd2, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF,
                    8'(i), 0, 1'b0, rsp, lat);

    // Full put then get.
    applyStimulus(PutFullData, 2'd2, 32'h10, 32'hDEADBEEF, 4'hF, 8'h21, 0, 1'b0, rsp, lat);
    checkOutput("put_opcode", 32'(rsp.d_opcode), 32'(AccessAck));
    checkOutput("put_error",  32'(rsp.d_error),  32'd0);
    checkOutput("put_size",   32'(rsp.d_size),   32'd2);
    checkOutput("put_source", 32'(rsp.d_source), 32'h21);
    applyStimulus(Get, 2'd2, 32'h10, 32'h0, 4'hF, 8'h22, 0, 1'b0, rsp, lat);
    checkOutput("get_opcode",  32'(rsp.d_opcode), 32'(AccessAckData));
    checkOutput("get_data",    rsp.d_data,        32'hDEADBEEF);
    checkOutput("get_latency", 32'(lat),          32'(RespDelay + 1));

    // Partial put.
    applyStimulus(PutPartialData, 2'd2, 32'h10, 32'h11223344, 4'b0101, 8'h23, 0, 1'b0, rsp, lat);
    checkOutput("pput_error", 32'(rsp.d_error), 32'd0);
    applyStimulus(Get, 2'd2, 32'h10, 32'h0, 4'h0, 8'h24, 0, 1'b0, rsp, lat);
    checkOutput("pput_readback", rsp.d_data, 32'hDE22BE44);

    // Errors.
    applyStimulus(Get, 2'd2, 32'(Depth * 4), 32'h0, 4'hF, 8'h25, 0, 1'b0, rsp, lat);
    checkOutput("oor_get_error", 32'(rsp.d_error), 32'd1);
    checkOutput("oor_get_data",  rsp.d_data,       32'd0);
    applyStimulus(PutFullData, 2'd2, 32'(Depth * 4), 32'hCAFEF00D, 4'hF, 8'h26, 0, 1'b0, rsp, lat);
    checkOutput("oor_put_error", 32'(rsp.d_error), 32'd1);
    applyStimulus(Get, 2'd2, 32'h0, 32'h0, 4'hF, 8'h27, 0, 1'b0, rsp, lat);
    checkOutput("no_alias_word0", rsp.d_data, 32'h1000_0000);
    applyStimulus(Get, 2'd2, 32'h12, 32'h0, 4'hF, 8'h28, 0, 1'b0, rsp, lat);
    checkOutput("misaligned_error", 32'(rsp.d_error), 32'd1);

    // Delay and backpressure.
    applyStimulus(Get, 2'd2, 32'h10, 32'h0, 4'hF, 8'h5A, 5, 1'b0, rsp, lat);
    checkOutput("bp_latency",       32'(lat),          32'(RespDelay + 1));
    checkOutput("bp_data",          rsp.d_data,        32'hDE22BE44);
    checkOutput("bp_source",        32'(rsp.d_source), 32'h5A);
    checkOutput("bp_d_valid_after", 32'(tlO.d_valid),  32'd0);
    checkOutput("bp_a_ready_after", 32'(tlO.a_ready),  32'd1);

    // Mid-operation reset while waiting; the write already landed.
    @(posedge clk);
    #1;
    tlI.a_valid   = 1'b1;
    tlI.a_opcode  = PutFullData;
    tlI.a_size    = 2'd2;
    tlI.a_address = 32'h10;
    tlI.a_data    = 32'h0BADF00D;
    tlI.a_mask    = 4'hF;
    tlI.a_source  = 8'h77;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tlO.a_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("midrst_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 tlI.a_valid = 1'b0;
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("midrst_d_valid", 32'(tlO.d_valid), 32'd0);
    checkOutput("midrst_a_ready", 32'(tlO.a_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tlO.d_valid) seen++;
    end
    checkOutput("midrst_no_response", 32'(seen), 32'd0);
    applyStimulus(Get, 2'd2, 32'h10, 32'h0, 4'hF, 8'h78, 0, 1'b0, rsp, lat);
    checkOutput("midrst_mem_kept", rsp.d_data, 32'h0BADF00D);

    // Randomised traffic checked by the model.
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 3 || r == 9) op = Get;
      else if (r <= 5) op = PutFullData;
      else if (r <= 7) op = PutPartialData;
      else begin
        op = 3'($urandom_range(2, 7));
        if (op == Get) op = 3'd5;
      end
      size = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      r = $urandom_range(0, 9);
      if (r == 0)
        addr = 32'(Depth * 4) + 32'($urandom_range(0, 1023)) * 32'd4;
      else if (r == 1)
        addr = $urandom | 32'h8000_0000;
      else if (r == 2)
        addr = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else
        addr = 32'($urandom_range(0, 15)) * 32'd4;
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      applyStimulus(op, size, addr, $urandom, mask, 8'($urandom),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), rsp, lat);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
